dcache_ctrl: RTL and testbench

// - Controller for a direct-mapped, write-through, no-write-allocate data cache placed between the DataBus

---
 rtl/cache_pkg.sv | 38 +++
 rtl/cache_data_array.sv | 29 ++
 rtl/dcache_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: shared geometry, FSM state encoding and address helpers for the
// direct-mapped data cache (dcache_ctrl and cache_data_array).
package cache_pkg;

  localparam int ADDR_W = 32;
  localparam int LINES  = 64;
  localparam int WORDS  = 4;
  localparam int IDX_W  = $clog2(LINES);
  localparam int OFF_W  = $clog2(WORDS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W - 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REFILL    = 2'd1,
    WRITE_MEM = 2'd2,
    WDONE     = 2'd3
  } state_e;

  // Byte address viewed as its cache fields, MSB first.
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [OFF_W-1:0] word;
    logic [1:0]       boff;
  } addr_t;

  function automatic addr_t addr_split(input logic [ADDR_W-1:0] a);
    return addr_t'(a);
  endfunction

  // Word-aligned byte address of one word inside a line.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [TAG_W-1:0] tag,
                                                  input logic [IDX_W-1:0] idx,
                                                  input logic [OFF_W-1:0] word);
    return {tag, idx, word, 2'b00};
  endfunction

endpackage

// File: rtl/cache_data_array.sv
// cache_data_array: LINES*WORDS x ADDR_W data store for the cache.
// Ports:
//   clk   - clock, rising edge
//   we    - write enable for the addressed word
//   idx   - line index (shared by read and write)
//   word  - word within line (shared by read and write)
//   wdata - write data
//   rdata - asynchronous read of [idx][word]
module cache_data_array
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [OFF_W-1:0]  word,
  input  logic [ADDR_W-1:0] wdata,
  output logic [ADDR_W-1:0] rdata
);

  // Contents need no reset: a line is only read after the valid bit is set.
  logic [ADDR_W-1:0] mem_q [LINES*WORDS];

  always_ff @(posedge clk) begin
    if (we) mem_q[{idx, word}] <= wdata;
  end

  assign rdata = mem_q[{idx, word}];

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through, no-write-allocate data cache
// controller between the core load/store port and a handshake memory port.
// Ports:
//   CLK, RST             - clock, synchronous active-high reset
//   MemRead, MemWrite    - core load/store requests, held while Stall=1
//   Addr, WriteData      - core byte address and store data
//   ReadData             - load data, valid when MemRead=1 and Stall=0
//   Stall                - combinational, core holds state this cycle
//   mem_req/mem_we       - registered memory request and direction
//   mem_addr/mem_wdata   - registered word address and write data
//   mem_rdata/mem_ready  - memory read data and one-cycle completion strobe
//
// state     | meaning
// IDLE      | serve hits at zero latency, launch refill or write-through
// REFILL    | fetch WORDS beats of the missing line into the data array
// WRITE_MEM | write-through pending, update the array on hit when it lands
// WDONE     | one unstalled cycle so the core retires the store
module dcache_ctrl
  import cache_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [ADDR_W-1:0] WriteData,
  output logic [ADDR_W-1:0] ReadData,
  output logic              Stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] mem_wdata,
  input  logic [ADDR_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  state_e            state_q, state_d;
  logic [OFF_W-1:0]  cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [TAG_W-1:0]  miss_tag_q, miss_tag_d;
  logic [IDX_W-1:0]  miss_idx_q, miss_idx_d;
  logic [OFF_W-1:0]  miss_word_q, miss_word_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q [LINES];
  logic              tag_we;

  addr_t             a_f;
  logic [1:0]        unused_boff;
  logic              hit, miss_line_hit, beat, stall_c;
  logic              arr_we;
  logic [IDX_W-1:0]  arr_idx;
  logic [OFF_W-1:0]  arr_word;
  logic [ADDR_W-1:0] arr_wdata, arr_rdata;

  assign a_f         = addr_split(Addr);
  assign unused_boff = a_f.boff;

  assign hit           = valid_q[a_f.idx] && (tag_q[a_f.idx] == a_f.tag);
  // Store hit is judged on the latched line, not on the live core address.
  assign miss_line_hit = valid_q[miss_idx_q] && (tag_q[miss_idx_q] == miss_tag_q);
  assign beat          = mem_req_q && mem_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    miss_tag_d  = miss_tag_q;
    miss_idx_d  = miss_idx_q;
    miss_word_d = miss_word_q;
    valid_d     = valid_q;
    tag_we      = 1'b0;
    stall_c     = 1'b0;
    arr_we      = 1'b0;
    arr_idx     = a_f.idx;
    arr_word    = a_f.word;
    arr_wdata   = mem_rdata;

    case (state_q)
      IDLE: begin
        if (MemWrite) begin
          stall_c     = 1'b1;
          state_d     = WRITE_MEM;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = {Addr[ADDR_W-1:2], 2'b00};
          mem_wdata_d = WriteData;
          miss_tag_d  = a_f.tag;
          miss_idx_d  = a_f.idx;
          miss_word_d = a_f.word;
        end else if (MemRead && !hit) begin
          stall_c     = 1'b1;
          state_d     = REFILL;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = word_addr(a_f.tag, a_f.idx, '0);
          miss_tag_d  = a_f.tag;
          miss_idx_d  = a_f.idx;
          miss_word_d = a_f.word;
          // Invalidate up front so an abandoned refill never looks resident.
          valid_d[a_f.idx] = 1'b0;
        end
      end

      REFILL: begin
        stall_c  = 1'b1;
        arr_idx  = miss_idx_q;
        arr_word = cnt_q;
        if (beat) begin
          arr_we = 1'b1;
          if (cnt_q == OFF_W'(WORDS - 1)) begin
            mem_req_d           = 1'b0;
            valid_d[miss_idx_q] = 1'b1;
            tag_we              = 1'b1;
            state_d             = IDLE;
          end else begin
            cnt_d      = cnt_q + OFF_W'(1);
            mem_addr_d = word_addr(miss_tag_q, miss_idx_q, cnt_q + OFF_W'(1));
          end
        end
      end

      WRITE_MEM: begin
        stall_c   = 1'b1;
        arr_idx   = miss_idx_q;
        arr_word  = miss_word_q;
        arr_wdata = mem_wdata_q;
        if (beat) begin
          mem_req_d = 1'b0;
          arr_we    = miss_line_hit;
          state_d   = WDONE;
        end
      end

      WDONE: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      miss_tag_q  <= '0;
      miss_idx_q  <= '0;
      miss_word_q <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      miss_tag_q  <= miss_tag_d;
      miss_idx_q  <= miss_idx_d;
      miss_word_q <= miss_word_d;
      valid_q     <= valid_d;
    end
  end

  // Tags are qualified by valid_q, so they carry no reset.
  always_ff @(posedge CLK) begin
    if (tag_we && !RST) tag_q[miss_idx_q] <= miss_tag_q;
  end

  cache_data_array u_data (
    .clk   (CLK),
    .we    (arr_we && !RST),
    .idx   (arr_idx),
    .word  (arr_word),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  assign Stall     = stall_c && !RST;
  assign ReadData  = RST ? '0 : arr_rdata;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
module tb_dcache_ctrl;

  localparam int LAT = 3;

  logic        CLK = 1'b0;
  logic        RST, MemRead, MemWrite, Stall;
  logic [31:0] Addr, WriteData, ReadData;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 CLK = ~CLK;

  dcache_ctrl dut (
    .CLK(CLK), .RST(RST), .MemRead(MemRead), .MemWrite(MemWrite),
    .Addr(Addr), .WriteData(WriteData), .ReadData(ReadData), .Stall(Stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  typedef struct {
    bit          is_load;
    logic [31:0] data;
    int          stall;
  } resp_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  int errors = 0;
  int checks = 0;
  int beats  = 0;
  int run    = 0;
  int lat_c  = 0;

  resp_t       resp_q[$];
  txn_t        txn_q[$];
  logic [31:0] dev_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  bit          res_valid [64];
  logic [21:0] res_tag   [64];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  function automatic logic [31:0] dev_rd(input logic [31:0] a);
    if (dev_mem.exists(a)) return dev_mem[a];
    return init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_word(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  // Memory: each beat completes in the third cycle it is outstanding.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
  end

  always @(posedge CLK) begin
    #1;
    if (RST || !mem_req) begin
      mem_ready = 1'b0;
      lat_c     = 0;
    end else if (mem_ready) begin
      mem_ready = 1'b0;
      lat_c     = 1;
    end else begin
      lat_c++;
      if (lat_c >= LAT) begin
        mem_ready = 1'b1;
        if (mem_we) dev_mem[mem_addr] = mem_wdata;
        else        mem_rdata = dev_rd(mem_addr);
      end
    end
    if (!mem_ready) mem_rdata = $urandom;
  end

  // Monitor: memory beats against expected transactions, core completions
  // against expected responses.
  always @(negedge CLK) begin
    txn_t  t;
    resp_t r;
    if (RST) begin
      run = 0;
    end else begin
      if (mem_req && mem_ready) begin
        beats++;
        if (txn_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_mem_txn: got addr %h we %b, none expected", mem_addr, mem_we);
        end else begin
          t = txn_q.pop_front();
          chk("mem_we", 32'(mem_we), 32'(t.we));
          chk("mem_addr", mem_addr, t.addr);
          if (t.we) chk("mem_wdata", mem_wdata, t.wdata);
        end
      end
      if (MemRead || MemWrite) begin
        if (Stall) begin
          run++;
        end else begin
          if (resp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_completion: got completion, none expected");
          end else begin
            r = resp_q.pop_front();
            if (r.is_load) chk("read_data", ReadData, r.data);
            chk("stall_cycles", 32'(run), 32'(r.stall));
          end
          run = 0;
        end
      end
    end
  end

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (Stall && n < 200);
    if (Stall) begin
      checks++;
      errors++;
      $display("FAIL request_timeout: Stall still 1 after %0d cycles, required 0", n);
      finish_run();
    end
    @(posedge CLK);
    #1;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a);
    resp_t       r;
    txn_t        t;
    logic [5:0]  idx;
    logic [21:0] tag;
    bit          hit;
    idx = a[9:4];
    tag = a[31:10];
    hit = res_valid[idx] && (res_tag[idx] == tag);
    r.is_load = 1'b1;
    r.data    = ref_rd({a[31:2], 2'b00});
    r.stall   = hit ? 0 : 4 * LAT + 1;
    if (!hit) begin
      for (int k = 0; k < 4; k++) begin
        t.we    = 1'b0;
        t.addr  = {a[31:4], 4'b0000} + 32'(4 * k);
        t.wdata = '0;
        txn_q.push_back(t);
      end
      res_valid[idx] = 1'b1;
      res_tag[idx]   = tag;
    end
    resp_q.push_back(r);
    MemRead   = 1'b1;
    MemWrite  = 1'b0;
    Addr      = a;
    WriteData = $urandom;
    wait_done();
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input bit with_read);
    resp_t r;
    txn_t  t;
    t.we    = 1'b1;
    t.addr  = {a[31:2], 2'b00};
    t.wdata = d;
    txn_q.push_back(t);
    r.is_load = 1'b0;
    r.data    = '0;
    r.stall   = LAT + 1;
    resp_q.push_back(r);
    ref_mem[{a[31:2], 2'b00}] = d;
    MemRead   = with_read;
    MemWrite  = 1'b1;
    Addr      = a;
    WriteData = d;
    wait_done();
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((resp_q.size() != 0 || txn_q.size() != 0) && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk({name, "_resp_left"}, 32'(resp_q.size()), 32'd0);
    chk({name, "_txn_left"}, 32'(txn_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    checks++;
    errors++;
    $display("FAIL global_timeout: simulation did not finish");
    finish_run();
  end

  initial begin
    int          n;
    logic [31:0] a;
    int          idx_pool [5];
    idx_pool = '{0, 1, 16, 17, 63};

    RST       = 1'b1;
    MemRead   = 1'b1;
    MemWrite  = 1'b0;
    Addr      = 32'h100;
    WriteData = '0;
    for (int i = 0; i < 64; i++) res_valid[i] = 1'b0;

    // Requests are masked while reset is held.
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("reset_stall", 32'(Stall), 32'd0);
    chk("reset_rdata", ReadData, 32'd0);
    chk("reset_mem_req", 32'(mem_req), 32'd0);
    chk("reset_mem_we", 32'(mem_we), 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_mem_wdata", mem_wdata, 32'd0);
    @(posedge CLK);
    #1;
    RST     = 1'b0;
    MemRead = 1'b0;
    @(posedge CLK);
    #1;

    do_load(32'h0000_0100);
    do_load(32'h0000_0108);
    drain("t2");
    do_store(32'h0000_0104, 32'hDEAD_BEEF, 1'b0);
    do_load(32'h0000_0104);
    do_store(32'h0000_2000, 32'h1234_5678, 1'b0);
    do_load(32'h0000_2000);
    do_load(32'h0000_0400);
    // 0x500 shares the line index of 0x100, so it evicts it.
    do_load(32'h0000_0500);
    do_load(32'h0000_0100);
    drain("t5");

    // Abandon a refill after its second beat.
    begin
      txn_t t;
      do_load(32'h0000_0500);
      for (int k = 0; k < 2; k++) begin
        t.we    = 1'b0;
        t.addr  = 32'h0000_0100 + 32'(4 * k);
        t.wdata = '0;
        txn_q.push_back(t);
      end
      n = beats;
      MemRead = 1'b1;
      Addr    = 32'h0000_0100;
      while (beats < n + 2 && (beats - n) >= 0 && run < 100) @(posedge CLK);
      #1;
      RST     = 1'b1;
      MemRead = 1'b0;
      @(negedge CLK);
      chk("rst_mid_refill_stall", 32'(Stall), 32'd0);
      chk("rst_mid_refill_rdata", ReadData, 32'd0);
      @(posedge CLK);
      #1;
      RST = 1'b0;
      @(negedge CLK);
      chk("after_rst_mem_req", 32'(mem_req), 32'd0);
      chk("after_rst_stall", 32'(Stall), 32'd0);
      chk("after_rst_beats", 32'(beats - n), 32'd2);
      chk("after_rst_txn_left", 32'(txn_q.size()), 32'd0);
      txn_q.delete();
      resp_q.delete();
      for (int i = 0; i < 64; i++) res_valid[i] = 1'b0;
      @(posedge CLK);
      #1;
      do_load(32'h0000_0100);
      do_load(32'h0000_0104);
    end

    for (int i = 0; i < 300; i++) begin
      a = {20'(0), 2'($urandom_range(0, 3)), 6'(idx_pool[$urandom_range(0, 4)]),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 9) < 6) do_load(a);
      else do_store(a, $urandom, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge CLK);
      #0;
    end

    drain("final");
    finish_run();
  end

endmodule
